traffic_phase_scheduler: RTL
============================

// Module: traffic_phase_scheduler
// PURPOSE
//  Phase sequencer for one intersection: main road (RYG), protected left turn (LRYG), pedestrian walk.
//  Green time scales with 3-bit queue levels. The left phase is skipped when its queue is empty.
//  Pedestrian requests are latched and served once per cycle. Maintenance flash mode is supported.
//  Sits after the 1 Hz second generator and drives the lamp outputs.
// PARAMETERS
//  MIN_GREEN   10  main green seconds at H=0
//  STEP         3  extra main green seconds per unit of H
//  MAX_GREEN   30  clamp for main green seconds
//  LEFT_BASE    4  left green = LEFT_BASE + L seconds
//  YELLOW       3  yellow seconds (main and left)
//  ALL_RED      2  all-red clearance seconds
//  WALK         7  walk steady seconds
//  PED_FLASH    5  walk flashing seconds
//  CW           5  timer width; every duration must be <= 2**CW
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-low reset
//  sec_tick   in   1  one-clk pulse per second
//  H          in   3  main-road queue level, 0..7
//  L          in   3  left-turn queue level, 0..7
//  ped_req    in   1  pedestrian button pulse, clk domain
//  flash_en   in   1  maintenance flash request, level
//  RYG        out  3  main lamps {R,Y,G}
//  LRYG       out  4  left lamps {R,Y,G,ARW}; ARW = protected arrow, set with G
//  walk       out  1  walk lamp; blinks during PED_FLASH
//  ped_pend   out  1  latched pedestrian request
//  count_out  out  CW remaining ticks in current state, minus 1
//  phase      out  3  current state encoding
// BEHAVIOUR
//  - Timer is loaded with D-1 on the clk of entry to each timed state, where D is that state's duration.
//    It decrements on each sec_tick while >0.
//  - The state ends on the clk where sec_tick=1 and the timer =0, so each state lasts exactly D ticks.
//  - States: ALL_R, MAIN_G, MAIN_Y, LEFT_G, LEFT_Y, PED_W, PED_F, FLASH.
//  - A 2-bit next_sel register holds {MAIN, LEFT, PED, FLASH}; it tells ALL_R where to go.
//  - ALL_R -> next_sel target.
//  - MAIN_G -> MAIN_Y. Main green D = min(MIN_GREEN + STEP*H, MAX_GREEN).
//    H is sampled on the entry clk and is not re-read during the state.
//  - MAIN_Y -> ALL_R. next_sel is chosen on that clk with priority FLASH (flash_en), LEFT (L!=0), PED (ped_pend), MAIN.
//  - LEFT_G -> LEFT_Y -> ALL_R. Left green D = LEFT_BASE + L, with L sampled on entry.
//    next_sel is then chosen with priority FLASH, PED, MAIN.
//  - PED_W -> PED_F -> ALL_R. next_sel is then chosen with priority FLASH, MAIN.
//  - flash_en=1 during MAIN_G or LEFT_G forces the matching yellow on the next clk.
//    This overrides the minimum green; the yellow and all-red are never shortened.
//  - flash_en=1 during PED_W forces PED_F.
//  - FLASH: no timer. Main Y and left R blink, toggling on each sec_tick; all other lamps are off; walk=0.
//  - FLASH exits on the first sec_tick with flash_en=0. It goes to ALL_R (full ALL_RED) with next_sel=MAIN.
//  - ped_pend is set by ped_req and cleared on the clk of entry to PED_W.
//    If ped_req arrives on that same clk, ped_pend stays 1.
//  - Lamp decode is registered: outputs change one clk after the state changes.
//    - ALL_R, PED_*: RYG=100, LRYG=1000.
//    - MAIN_G: RYG=001. MAIN_Y: RYG=010. In both, LRYG=1000.
//    - LEFT_G: LRYG=0011. LEFT_Y: LRYG=0100. In both, RYG=100.
//  - Safety invariant: at most one of {RYG G or Y, LRYG G or Y, walk} is active in any clk.
//  - Reset (async, reset=0):
//    - state=ALL_R, timer=ALL_RED-1, next_sel=MAIN, ped_pend=0, blink=0.
//    - RYG=100, LRYG=1000, walk=0, count_out=ALL_RED-1, phase=ALL_R.
//    - Reset asserted mid-phase takes effect immediately; no yellow is inserted.
//  - sec_tick and a state exit on the same clk: the load of the next state wins over the decrement.
//  - The green-time sum is computed at 6 bits before the clamp, so there is no wrap.
// STRUCTURE
//  - Shared package traffic_pkg:
//    - state encodings (ST_ALL_R..ST_FLASH) and next_sel codes;
//    - lamp constants (LAMP_R=3'b100, LAMP_Y, LAMP_G, LLAMP_*).
//  - One sub-module, phase_timer: a CW-bit down-counter with inputs load, load_val, tick and output zero.
//  - Next-state logic, next_sel, ped latch and lamp decode stay in this module.
// TESTING
//  - Reset, then H=0, L=0, no requests -> ALL_R 2 ticks, MAIN_G 10, MAIN_Y 3, ALL_R 2, MAIN_G 10, repeating; LRYG stays 1000.
//  - H=7 -> MAIN_G lasts 30 ticks (31 clamped). H=4 -> 22 ticks. Changing H mid-green does not alter the current green.
//  - L=3 during MAIN_Y -> after ALL_R: LEFT_G 7 ticks with LRYG=0011 and RYG=100, then LEFT_Y 3, ALL_R 2, MAIN_G.
//  - ped_req pulse in MAIN_G with L=0 -> ped_pend=1, then MAIN_Y, ALL_R, PED_W 7, PED_F 5 (walk blinking), ALL_R, MAIN_G.
//    ped_pend clears on PED_W entry. A second ped_req during PED_W re-sets ped_pend.
//  - flash_en=1 on the 2nd tick of MAIN_G -> MAIN_Y next clk (3 ticks), ALL_R 2, FLASH with main Y toggling per tick.
//    Drop flash_en -> ALL_R 2, MAIN_G.
//  - Assert reset during LEFT_G -> outputs all-red on the same clk. Release -> ALL_R 2 ticks, MAIN_G; ped_pend=0.
//  - Throughout, an assertion checks the safety invariant and that count_out never underflows.

Source files
------------

// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types for the intersection phase scheduler:
// state and next_sel encodings, lamp patterns.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_ALL_R  = 3'd0,
    ST_MAIN_G = 3'd1,
    ST_MAIN_Y = 3'd2,
    ST_LEFT_G = 3'd3,
    ST_LEFT_Y = 3'd4,
    ST_PED_W  = 3'd5,
    ST_PED_F  = 3'd6,
    ST_FLASH  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SEL_MAIN  = 2'd0,
    SEL_LEFT  = 2'd1,
    SEL_PED   = 2'd2,
    SEL_FLASH = 2'd3
  } sel_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [3:0] LLAMP_R   = 4'b1000;
  localparam logic [3:0] LLAMP_Y   = 4'b0100;
  localparam logic [3:0] LLAMP_G   = 4'b0011;
  localparam logic [3:0] LLAMP_OFF = 4'b0000;

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Intersection bus: tick/queue/request inputs, lamp and status outputs.
// master drives sec_tick,H,L,ped_req,flash_en; slave drives the rest.
interface traffic_phase_scheduler_if #(
  parameter int CW = 5
);
  logic          sec_tick;
  logic [2:0]    H;
  logic [2:0]    L;
  logic          ped_req;
  logic          flash_en;
  logic [2:0]    RYG;
  logic [3:0]    LRYG;
  logic          walk;
  logic          ped_pend;
  logic [CW-1:0] count_out;
  logic [2:0]    phase;

  modport master (
    output sec_tick, H, L, ped_req, flash_en,
    input  RYG, LRYG, walk, ped_pend, count_out, phase
  );

  modport slave (
    input  sec_tick, H, L, ped_req, flash_en,
    output RYG, LRYG, walk, ped_pend, count_out, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Per-state down-counter: load wins over tick, holds at zero.
// Ports: clk, reset(async low), load, load_val, tick -> count, zero.
module phase_timer #(
  parameter int CW      = 5,
  parameter int RST_VAL = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          tick,
  output logic [CW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= CW'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (tick && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase sequencer: main, protected left, pedestrian, flash.
// Ports: clk, reset(async low), bus (slave) carrying ticks, queues, lamps.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 10,
  parameter int STEP      = 3,
  parameter int MAX_GREEN = 30,
  parameter int LEFT_BASE = 4,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  parameter int WALK      = 7,
  parameter int PED_FLASH = 5,
  parameter int CW        = 5
) (
  input  logic clk,
  input  logic reset,
  traffic_phase_scheduler_if.slave bus
);

  state_t        state, state_nx;
  sel_t          next_sel, sel_nx;
  logic          ped_pend, blink;
  logic          tmr_load, tmr_zero, done;
  logic [CW-1:0] tmr_val, tmr_cnt;
  logic [5:0]    g_sum, g_main, g_left;
  logic [2:0]    ryg_q;
  logic [3:0]    lryg_q;
  logic          walk_q;
  logic          enter_ped;

  // 6-bit sums so H=7 cannot wrap before the clamp
  assign g_sum  = 6'(MIN_GREEN) + 6'(STEP) * {3'b000, bus.H};
  assign g_main = (g_sum > 6'(MAX_GREEN)) ? 6'(MAX_GREEN) : g_sum;
  assign g_left = 6'(LEFT_BASE) + {3'b000, bus.L};

  assign done = bus.sec_tick && tmr_zero;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_ALL_R: if (done) begin
        unique case (next_sel)
          SEL_MAIN:  state_nx = ST_MAIN_G;
          SEL_LEFT:  state_nx = ST_LEFT_G;
          SEL_PED:   state_nx = ST_PED_W;
          SEL_FLASH: state_nx = ST_FLASH;
          default:   state_nx = ST_MAIN_G;
        endcase
      end
      ST_MAIN_G: if (bus.flash_en || done) state_nx = ST_MAIN_Y;
      ST_MAIN_Y: if (done) state_nx = ST_ALL_R;
      ST_LEFT_G: if (bus.flash_en || done) state_nx = ST_LEFT_Y;
      ST_LEFT_Y: if (done) state_nx = ST_ALL_R;
      ST_PED_W:  if (bus.flash_en || done) state_nx = ST_PED_F;
      ST_PED_F:  if (done) state_nx = ST_ALL_R;
      ST_FLASH:  if (bus.sec_tick && !bus.flash_en) state_nx = ST_ALL_R;
      default:   state_nx = ST_ALL_R;
    endcase
  end

  // Where ALL_R goes next; only latched on the clk that enters ALL_R
  always_comb begin
    sel_nx = SEL_MAIN;
    if (bus.flash_en) begin
      sel_nx = SEL_FLASH;
    end else if (state == ST_MAIN_Y && bus.L != 3'd0) begin
      sel_nx = SEL_LEFT;
    end else if ((state == ST_MAIN_Y || state == ST_LEFT_Y) && ped_pend) begin
      sel_nx = SEL_PED;
    end
  end

  assign tmr_load = (state_nx != state);

  always_comb begin
    tmr_val = '0;
    unique case (state_nx)
      ST_ALL_R:  tmr_val = CW'(ALL_RED - 1);
      ST_MAIN_G: tmr_val = CW'(g_main - 6'd1);
      ST_MAIN_Y: tmr_val = CW'(YELLOW - 1);
      ST_LEFT_G: tmr_val = CW'(g_left - 6'd1);
      ST_LEFT_Y: tmr_val = CW'(YELLOW - 1);
      ST_PED_W:  tmr_val = CW'(WALK - 1);
      ST_PED_F:  tmr_val = CW'(PED_FLASH - 1);
      ST_FLASH:  tmr_val = '0;
      default:   tmr_val = '0;
    endcase
  end

  phase_timer #(
    .CW      (CW),
    .RST_VAL (ALL_RED - 1)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (bus.sec_tick),
    .count    (tmr_cnt),
    .zero     (tmr_zero)
  );

  assign enter_ped = (state_nx == ST_PED_W) && (state != ST_PED_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_ALL_R;
      next_sel <= SEL_MAIN;
      ped_pend <= 1'b0;
      blink    <= 1'b0;
    end else begin
      state    <= state_nx;
      // a press on the serving clk is kept for the next cycle
      ped_pend <= bus.ped_req | (ped_pend & ~enter_ped);
      if (state_nx == ST_ALL_R && state != ST_ALL_R) begin
        next_sel <= sel_nx;
      end
      // blinking phases start lit
      if (tmr_load) begin
        blink <= 1'b1;
      end else if (bus.sec_tick) begin
        blink <= ~blink;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ryg_q  <= LAMP_R;
      lryg_q <= LLAMP_R;
      walk_q <= 1'b0;
    end else begin
      ryg_q  <= LAMP_R;
      lryg_q <= LLAMP_R;
      walk_q <= 1'b0;
      unique case (state)
        ST_MAIN_G: ryg_q  <= LAMP_G;
        ST_MAIN_Y: ryg_q  <= LAMP_Y;
        ST_LEFT_G: lryg_q <= LLAMP_G;
        ST_LEFT_Y: lryg_q <= LLAMP_Y;
        ST_PED_W:  walk_q <= 1'b1;
        ST_PED_F:  walk_q <= blink;
        ST_FLASH: begin
          ryg_q  <= blink ? LAMP_Y : LAMP_OFF;
          lryg_q <= blink ? LLAMP_R : LLAMP_OFF;
        end
        default: ;
      endcase
    end
  end

  assign bus.RYG       = ryg_q;
  assign bus.LRYG      = lryg_q;
  assign bus.walk      = walk_q;
  assign bus.ped_pend  = ped_pend;
  assign bus.count_out = tmr_cnt;
  assign bus.phase     = state;

endmodule
